// File: rtl/shift_sequencer.sv
// Multi-cycle STEP-bit shifter for the ALU shift path; done rises ceil(min(shamt,32)/STEP) edges after accept.
// No backpressure: start is honoured only in IDLE/DONE, ignored (not queued) while busy.
module shift_sequencer #(
  parameter int STEP = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] operand,
  input  logic [5:0]  shamt,
  output logic        busy,
  output logic        done,
  output logic [31:0] result
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam logic [5:0] STEP_W = 6'(STEP);

  state_t      state, state_nxt;
  logic [1:0]  op_q, op_nxt;
  logic [5:0]  rem, rem_nxt;
  logic [31:0] result_nxt;
  logic [31:0] shamt_ext;
  logic [5:0]  rem_init;
  logic [5:0]  k;
  logic        accept;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      op_q   <= 2'b00;
      rem    <= 6'd0;
      result <= 32'd0;
    end else begin
      state  <= state_nxt;
      op_q   <= op_nxt;
      rem    <= rem_nxt;
      result <= result_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    op_nxt     = op_q;
    rem_nxt    = rem;
    result_nxt = result;
    shamt_ext  = {26'd0, shamt};
    accept     = start && ((state == IDLE) || (state == DONE));
    // Amounts of 32 and above saturate; pass-through never shifts.
    rem_init   = (op == 2'b11) ? 6'd0 : ((shamt_ext >= 32'd32) ? 6'd32 : shamt);
    k          = (rem < STEP_W) ? rem : STEP_W;

    case (state)
      IDLE, DONE: begin
        if (accept) begin
          result_nxt = operand;
          op_nxt     = op;
          rem_nxt    = rem_init;
          state_nxt  = (rem_init != 6'd0) ? SHIFT : DONE;
        end else begin
          state_nxt = IDLE;
        end
      end
      SHIFT: begin
        case (op_q)
          2'b00:   result_nxt = result << k;
          2'b01:   result_nxt = result >> k;
          2'b10:   result_nxt = $signed(result) >>> k;
          default: result_nxt = result;
        endcase
        rem_nxt = rem - k;
        if (rem_nxt == 6'd0) state_nxt = DONE;
      end
      default: state_nxt = IDLE;
    endcase

    busy = (state == SHIFT);
    done = (state == DONE);
  end

endmodule
